// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte requesters.
//   Ports: clk/rst_n; req0/data0/ack0/done0 (processor), req1/data1/ack1/done1
//   (receive echo); tx_data/tx_start/tx_busy to the UART; grant (one-hot owner)
//   and err_timeout (sticky).
// Latency: grant decided in IDLE, ack one cycle later; tx_start held HOLD_CYCLES;
//   done one cycle after tx_busy is seen low. Back-to-back grants are spaced
//   at least HOLD_CYCLES+3 cycles apart.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating priority on
//   simultaneous requests; otherwise requester 0 has fixed priority.
module uart_tx_arbiter #(
  parameter int HOLD_CYCLES    = 1042,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  output logic       done0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       done1,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       err_timeout
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          launch;
  logic          win1;
  logic          timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer to the requester served most recently; resets to 1 so that
  // requester 0 wins the first contended arbitration.
  logic last;

  always_comb begin
    win1 = req1 & (~req0 | ~last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (launch) begin
      last <= win1;
    end
  end
`else
  always_comb begin
    win1 = req1 & ~req0;
  end
`endif

  assign launch = (state == IDLE) && !tx_busy && (req0 || req1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        // A low tx_busy wins over the timeout in the same cycle.
        if (!tx_busy) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      grant       <= 2'b00;
      tx_data     <= 8'h00;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack0  <= launch & ~win1;
      ack1  <= launch & win1;
      if (launch) begin
        grant   <= {win1, ~win1};
        tx_data <= win1 ? data1 : data0;
      end else if (state != IDLE && state_nxt == IDLE) begin
        // Leaving DONE or timing out of DRAIN releases ownership; tx_data
        // is left as-is since nothing consumes it outside a transfer.
        grant <= 2'b00;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Decoded from registered state so reset drops them immediately.
  assign tx_start = (state == START);
  assign done0    = (state == DONE) & grant[0];
  assign done1    = (state == DONE) & grant[1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with default parameters: directed scenarios
// plus randomized transfers checked against a transaction-level model of the
// arbitration rule and cycle budget, with a simple UART busy emulation.
module tb_uart_tx_arbiter;

  localparam int HOLD    = 1042;
  localparam int TIMEOUT = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, done0, done1;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [1:0] grant;
  logic       err_timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: requester served last (1 after reset), and timing of the
  // previous ack for grant-spacing checks.
  int last_win      = 1;
  int prev_ack_cyc  = -1;
  int prev_drain    = 0;
  logic exp_err     = 1'b0;

  uart_tx_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .ack0(ack0), .done0(done0),
    .req1(req1), .data1(data1), .ack1(ack1), .done1(done1),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_winner(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last_win == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  // One full transfer. drain_busy = number of DRAIN cycles the UART stays
  // busy; to_mode keeps tx_busy high forever to provoke the timeout.
  // spaced=1 means this call directly follows a completed transfer.
  task automatic xfer(input logic r0, input logic r1, input logic [7:0] d0,
                      input logic [7:0] d1, input int drain_busy,
                      input bit to_mode, input bit spaced);
    int w, n, bad_data, bad_done;
    logic [7:0] exp_byte;
    w        = pick_winner(r0, r1);
    exp_byte = (w == 1) ? d1 : d0;
    req0 = r0; req1 = r1; data0 = d0; data1 = d1; tx_busy = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ack0 || ack1) && n < 20);
    chk("ack_latency", n, 1);
    chk("ack0", ack0, (w == 0));
    chk("ack1", ack1, (w == 1));
    chk("grant", grant, (w == 1) ? 2'b10 : 2'b01);
    chk("tx_data", tx_data, exp_byte);
    if (spaced) chk("grant_spacing", cyc - prev_ack_cyc, HOLD + prev_drain + 2);
    prev_ack_cyc = cyc;
    last_win = w;
    req0 = 1'b0; req1 = 1'b0;
    data0 = $urandom; data1 = $urandom;
    tx_busy = 1'b1;
    n = 1; bad_data = 0; bad_done = 0;
    tick();
    chk("ack_one_cycle", {ack0, ack1}, 2'b00);
    while (tx_start && n < HOLD + 10) begin
      n++;
      if (tx_data !== exp_byte) bad_data++;
      if (done0 || done1 || ack0 || ack1) bad_done++;
      tick();
    end
    chk("start_len", n, HOLD);
    chk("start_data_stable", bad_data, 0);
    chk("start_no_pulses", bad_done, 0);
    if (to_mode) begin
      n = 1; bad_done = 0;
      while (!err_timeout && n < TIMEOUT + 10) begin
        if (done0 || done1) bad_done++;
        tick();
        n++;
      end
      chk("timeout_cycles", n - 1, TIMEOUT);
      chk("timeout_no_done", bad_done + (done0 | done1), 0);
      chk("timeout_grant", grant, 2'b00);
      exp_err = 1'b1;
      prev_drain = TIMEOUT;
      tx_busy = 1'b0;
      tick();
      chk("timeout_idle_tx_start", tx_start, 1'b0);
      prev_ack_cyc = -1000000;
    end else begin
      for (int i = 0; i < drain_busy; i++) begin
        if (done0 || done1) bad_done++;
        tick();
      end
      tx_busy = 1'b0;
      tick();
      chk("drain_no_early_done", bad_done, 0);
      chk("done0", done0, (w == 0));
      chk("done1", done1, (w == 1));
      chk("done_data_stable", tx_data, exp_byte);
      chk("err_sticky", err_timeout, exp_err);
      prev_drain = drain_busy + 1;
      tick();
      chk("idle_grant", grant, 2'b00);
      chk("idle_no_done", {done0, done1}, 2'b00);
    end
  endtask

  initial begin
    int n;
    logic r0, r1;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_grant", grant, 2'b00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_pulses", {ack0, ack1, done0, done1}, 4'b0000);
    chk("rst_err", err_timeout, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic single transfer from requester 0.
    xfer(1'b1, 1'b0, 8'h41, 8'h00, 3, 1'b0, 1'b0);
    // Contended requests, back to back with minimal drain.
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 1'b1, 8'($urandom), 8'($urandom), 0, 1'b0, 1'b1);

    // Busy UART blocks the grant in IDLE.
    tx_busy = 1'b1; req1 = 1'b1; data1 = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_idle_grant", {grant, ack0, ack1}, 4'b0000);
    end
    xfer(1'b0, 1'b1, 8'h00, 8'h5A, 1, 1'b0, 1'b0);

    // Randomized transfers.
    for (int i = 0; i < 8; i++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r1 = 1'b1;
      xfer(r0, r1, 8'($urandom), 8'($urandom), $urandom_range(0, 20), 1'b0, 1'b0);
    end

    // Dropped request while idle and not granted: ignored.
    req0 = 1'b0; req1 = 1'b0;
    tx_busy = 1'b1; req0 = 1'b1; tick(); req0 = 1'b0; tx_busy = 1'b0; tick();
    chk("dropped_req_ignored", {grant, ack0, ack1, tx_start}, 5'b00000);

    // Timeout, then a normal transfer sees err_timeout still set.
    xfer(1'b1, 1'b0, 8'hC3, 8'h00, 0, 1'b1, 1'b0);
    chk("err_set", err_timeout, 1'b1);
    xfer(1'b0, 1'b1, 8'h00, 8'h3C, 2, 1'b0, 1'b0);

    // Reset at START cycle 500 aborts the transfer.
    req1 = 1'b1; data1 = 8'h77;
    n = 0;
    do begin tick(); n++; end while (!ack1 && n < 20);
    chk("rst_case_ack1", ack1, 1'b1);
    tx_busy = 1'b1;
    for (int i = 1; i < 500; i++) tick();
    chk("rst_case_in_start", tx_start, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_start", tx_start, 1'b0);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_err", err_timeout, 1'b0);
    tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_pulses", {ack0, ack1, done0, done1}, 4'b0000);
    end
    rst_n = 1'b1;
    last_win = 1; exp_err = 1'b0;
    xfer(1'b0, 1'b1, 8'h00, 8'h77, 0, 1'b0, 1'b0);
    // Pointer reset: a contended request goes to requester 0 first.
    xfer(1'b1, 1'b1, 8'h12, 8'h34, 1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
